// File: rtl/mem_rd_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_rd_arbiter_pkg : shared bus widths and encodings for the read    |
// | arbiter.                                       Revision: 1.0         |
// +----------------------------------------------------------------------+
package mem_rd_arbiter_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mem_rd_arbiter_arb_sel2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_sel2 : 2-way requester select, fixed LSU priority or round-robin |
// | against the last grant.                        Revision: 1.0         |
// +----------------------------------------------------------------------+
module arb_sel2
    import mem_rd_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic   req_ifu,
    input  logic   req_lsu,
    input  owner_t last_grant,
    output logic   gnt_valid,
    output owner_t gnt_owner
);

    logic w_lsu_wins;

    // On contention in round-robin mode the master that was not granted last wins.
    assign w_lsu_wins = req_lsu && (!req_ifu || !RR_EN || (last_grant == OWN_IFU));
    assign gnt_valid  = req_ifu || req_lsu;
    assign gnt_owner  = w_lsu_wins ? OWN_LSU : OWN_IFU;

endmodule
`default_nettype wire

// File: rtl/mem_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_rd_arbiter : shares one memory read port between IFU and LSU,    |
// | dropping responses killed by flush. MEM_RD_ARB_RR_EN: round-robin.   |
// |                                                Revision: 1.0         |
// +----------------------------------------------------------------------+
module mem_rd_arbiter
    import mem_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              ifu_arvalid,
    input  logic [ADDR_W-1:0] ifu_araddr,
    output logic              ifu_arready,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    input  logic              ifu_rready,
    input  logic              lsu_arvalid,
    input  logic [ADDR_W-1:0] lsu_araddr,
    output logic              lsu_arready,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    input  logic              lsu_rready,
    output logic              mem_arvalid,
    output logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_arready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    output logic              mem_rready
);

    state_t            r_state;
    state_t            w_state_nxt;
    owner_t            r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_drop;
    logic              w_accept;
    logic              w_gnt_valid;
    owner_t            w_gnt_owner;
    owner_t            w_last;
    logic              w_fwd_ifu;
    logic              w_fwd_lsu;

`ifdef MEM_RD_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
    owner_t r_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last <= OWN_IFU;
        end else if (w_accept) begin
            r_last <= w_gnt_owner;
        end
    end
    assign w_last = r_last;
`else
    localparam bit RR_MODE = 1'b0;
    assign w_last = OWN_IFU;
`endif

    arb_sel2 #(
        .RR_EN      (RR_MODE)
    ) u_sel (
        .req_ifu    (ifu_arvalid),
        .req_lsu    (lsu_arvalid),
        .last_grant (w_last),
        .gnt_valid  (w_gnt_valid),
        .gnt_owner  (w_gnt_owner)
    );

    // Reset gates acceptance so no arready can pulse while the state is held.
    assign w_accept = (r_state == ST_IDLE) && !reset && !flush && w_gnt_valid;

    assign ifu_arready = w_accept && (w_gnt_owner == OWN_IFU);
    assign lsu_arready = w_accept && (w_gnt_owner == OWN_LSU);

    assign mem_arvalid = (r_state == ST_ADDR);
    assign mem_araddr  = r_addr;

    assign w_fwd_ifu  = (r_state == ST_DATA) && !r_drop && (r_owner == OWN_IFU);
    assign w_fwd_lsu  = (r_state == ST_DATA) && !r_drop && (r_owner == OWN_LSU);
    assign mem_rready = (r_state == ST_DATA) &&
                        (r_drop || (r_owner == OWN_LSU ? lsu_rready : ifu_rready));

    assign ifu_rvalid = w_fwd_ifu && mem_rvalid;
    assign ifu_rdata  = w_fwd_ifu ? mem_rdata : '0;
    assign ifu_rresp  = w_fwd_ifu ? mem_rresp : RESP_OKAY;
    assign lsu_rvalid = w_fwd_lsu && mem_rvalid;
    assign lsu_rdata  = w_fwd_lsu ? mem_rdata : '0;
    assign lsu_rresp  = w_fwd_lsu ? mem_rresp : RESP_OKAY;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)                 w_state_nxt = ST_ADDR;
            ST_ADDR: if (mem_arready)              w_state_nxt = ST_DATA;
            ST_DATA: if (mem_rvalid && mem_rready) w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_IFU;
            r_addr  <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner <= w_gnt_owner;
                r_addr  <= (w_gnt_owner == OWN_LSU) ? lsu_araddr : ifu_araddr;
            end
            // Drop is sampled registered, so a flush on the final handshake cycle
            // cannot suppress a response that was still live.
            if (w_state_nxt == ST_IDLE) begin
                r_drop <= 1'b0;
            end else if (flush && (r_state != ST_IDLE)) begin
                r_drop <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_rd_arbiter : table-driven cycle vectors plus contention and   |
// | reset sequences for mem_rd_arbiter.            Revision: 1.0         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem_rd_arbiter;

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;
    localparam logic [31:0] Z = 32'h0;
`ifdef MEM_RD_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic [31:0] mem_araddr, mem_rdata;
    logic [1:0]  mem_rresp;

    int   n_vec = 0;
    int   n_bad = 0;
    logic exp_last = 1'b0;

    mem_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
        .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rready(mem_rready)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        fl, iv;
        logic [31:0] ia;
        logic        lv;
        logic [31:0] la;
        logic        mar, mrv;
        logic [31:0] md;
        logic [1:0]  mr;
        logic        irr, lrr;
        logic        e_iar, e_lar, e_mav;
        logic [31:0] e_maddr;
        logic        e_irv, e_lrv, e_mrr;
        logic [31:0] e_rd;
        logic [1:0]  e_rr;
    } vec_t;

    vec_t tbl[$];
    vec_t t;

    task automatic drive(input vec_t v);
        flush       = v.fl;
        ifu_arvalid = v.iv;  ifu_araddr = v.ia;  ifu_rready = v.irr;
        lsu_arvalid = v.lv;  lsu_araddr = v.la;  lsu_rready = v.lrr;
        mem_arready = v.mar; mem_rvalid = v.mrv; mem_rdata  = v.md; mem_rresp = v.mr;
    endtask

    task automatic check(input vec_t v);
        logic       ok;
        logic [5:0] act, exp;
        act = {ifu_arready, lsu_arready, mem_arvalid, ifu_rvalid, lsu_rvalid, mem_rready};
        exp = {v.e_iar, v.e_lar, v.e_mav, v.e_irv, v.e_lrv, v.e_mrr};
        ok  = (act === exp);
        if (v.e_mav && (mem_araddr !== v.e_maddr)) ok = 1'b0;
        if (v.e_irv && ((ifu_rdata !== v.e_rd) || (ifu_rresp !== v.e_rr))) ok = 1'b0;
        if (v.e_lrv && ((lsu_rdata !== v.e_rd) || (lsu_rresp !== v.e_rr))) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got ctl(iar,lar,mav,irv,lrv,mrr)=%b addr=%h ifu=%h/%0d lsu=%h/%0d, want ctl=%b addr=%h data=%h/%0d",
                     v.name, act, mem_araddr, ifu_rdata, ifu_rresp, lsu_rdata, lsu_rresp,
                     exp, v.e_maddr, v.e_rd, v.e_rr);
        end
        if (v.e_iar) exp_last = 1'b0;
        if (v.e_lar) exp_last = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clock);
        drive(v);
        #1 check(v);
    endtask

    task automatic check_reset_state(input string name);
        vec_t z;
        z = '{name, O,O,Z,O,Z, O,O,Z,2'd0, O,O, O,O,O,Z, O,O,O,Z,2'd0};
        check(z);
        n_vec++;
        if (mem_araddr !== 32'h0) begin
            n_bad++;
            $display("FAIL %s_addr: got mem_araddr=%h, want 00000000", name, mem_araddr);
        end
    endtask

    // One complete contended transaction; the expected winner comes from the arbitration policy.
    task automatic contend(input int r);
        vec_t        v;
        logic        lsu_win;
        logic [31:0] wa;
        lsu_win = RR ? !exp_last : 1'b1;
        wa      = lsu_win ? 32'h200 : 32'h100;
        v = '{$sformatf("cont%0d_req", r), O,I,32'h100,I,32'h200, O,O,Z,2'd0, I,I,
              !lsu_win,lsu_win,O,Z, O,O,O,Z,2'd0};
        run_vec(v);
        v = '{$sformatf("cont%0d_addr", r), O,!lsu_win,32'h100,lsu_win,32'h200, I,O,Z,2'd0, I,I,
              O,O,I,wa, O,O,O,Z,2'd0};
        run_vec(v);
        v = '{$sformatf("cont%0d_data", r), O,O,Z,O,Z, O,I,32'hC0DE_0000 + r,2'd0, I,I,
              O,O,O,Z, !lsu_win,lsu_win,I,32'hC0DE_0000 + r,2'd0};
        run_vec(v);
        v = '{$sformatf("cont%0d_idle", r), O,O,Z,O,Z, O,O,Z,2'd0, I,I, O,O,O,Z, O,O,O,Z,2'd0};
        run_vec(v);
    endtask

    initial begin
        reset = 1'b1;
        t = '{"init", O,O,Z,O,Z, O,O,Z,2'd0, I,I, O,O,O,Z, O,O,O,Z,2'd0};
        drive(t);

        // fields: name fl iv ia lv la mar mrv md mr irr lrr | iar lar mav maddr irv lrv mrr rd rr
        t = '{"ifu_req",   O,I,32'h8000_0000,O,Z, I,O,Z,2'd0, I,I, I,O,O,Z, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"ifu_addr",  O,O,Z,O,Z, I,O,Z,2'd0, I,I, O,O,I,32'h8000_0000, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"ifu_data",  O,O,Z,O,Z, O,I,32'h1234_5678,2'd0, I,I, O,O,O,Z, I,O,I,32'h1234_5678,2'd0}; tbl.push_back(t);
        t = '{"ifu_idle",  O,O,Z,O,Z, O,O,Z,2'd0, I,I, O,O,O,Z, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"lsu_req3",  O,O,Z,I,32'h300, O,O,Z,2'd0, I,I, O,I,O,Z, O,O,O,Z,2'd0}; tbl.push_back(t);
        for (int k = 0; k < 5; k++) begin
            t = '{$sformatf("stall%0d", k), O,I,32'h100,O,Z, O,O,Z,2'd0, I,I, O,O,I,32'h300, O,O,O,Z,2'd0};
            tbl.push_back(t);
        end
        t = '{"stall_go",  O,I,32'h100,O,Z, I,O,Z,2'd0, I,I, O,O,I,32'h300, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"lsu_data3", O,I,32'h100,O,Z, O,I,32'hAAAA_5555,2'd0, I,I, O,O,O,Z, O,I,I,32'hAAAA_5555,2'd0}; tbl.push_back(t);
        t = '{"ifu_after", O,I,32'h100,O,Z, O,O,Z,2'd0, I,I, I,O,O,Z, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"ifu_addr1", O,O,Z,O,Z, I,O,Z,2'd0, I,I, O,O,I,32'h100, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"ifu_bp",    O,O,Z,O,Z, O,I,32'h5A5A_0001,2'd0, O,I, O,O,O,Z, I,O,O,32'h5A5A_0001,2'd0}; tbl.push_back(t);
        t = '{"ifu_bp_rel",O,O,Z,O,Z, O,I,32'h5A5A_0001,2'd0, I,I, O,O,O,Z, I,O,I,32'h5A5A_0001,2'd0}; tbl.push_back(t);
        t = '{"idle2",     O,O,Z,O,Z, O,O,Z,2'd0, I,I, O,O,O,Z, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"fl_req",    O,I,32'h400,O,Z, O,O,Z,2'd0, I,I, I,O,O,Z, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"fl_addr",   O,O,Z,O,Z, I,O,Z,2'd0, I,I, O,O,I,32'h400, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"fl_data0",  I,O,Z,O,Z, O,O,Z,2'd0, I,I, O,O,O,Z, O,O,I,Z,2'd0}; tbl.push_back(t);
        t = '{"fl_wait1",  O,O,Z,O,Z, O,O,Z,2'd0, O,I, O,O,O,Z, O,O,I,Z,2'd0}; tbl.push_back(t);
        t = '{"fl_wait2",  O,O,Z,O,Z, O,O,Z,2'd0, O,I, O,O,O,Z, O,O,I,Z,2'd0}; tbl.push_back(t);
        t = '{"fl_drop",   O,O,Z,O,Z, O,I,32'hDEAD_BEEF,2'd0, O,I, O,O,O,Z, O,O,I,Z,2'd0}; tbl.push_back(t);
        t = '{"drop_clr",  O,I,32'h500,O,Z, O,O,Z,2'd0, I,I, I,O,O,Z, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"late_addr", O,O,Z,O,Z, I,O,Z,2'd0, I,I, O,O,I,32'h500, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"late_fl",   I,O,Z,O,Z, O,I,32'hCAFE_F00D,2'd0, I,I, O,O,O,Z, I,O,I,32'hCAFE_F00D,2'd0}; tbl.push_back(t);
        t = '{"fl_idle",   I,I,32'h600,O,Z, O,O,Z,2'd0, I,I, O,O,O,Z, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"req600",    O,I,32'h600,O,Z, O,O,Z,2'd0, I,I, I,O,O,Z, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"addr_fl",   I,O,Z,O,Z, O,O,Z,2'd0, I,I, O,O,I,32'h600, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"addr_go",   O,O,Z,O,Z, I,O,Z,2'd0, I,I, O,O,I,32'h600, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"drop2",     O,O,Z,O,Z, O,I,32'h7777_7777,2'd0, O,I, O,O,O,Z, O,O,I,Z,2'd0}; tbl.push_back(t);
        t = '{"idle3",     O,O,Z,O,Z, O,O,Z,2'd0, I,I, O,O,O,Z, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"lsu_req7",  O,O,Z,I,32'h700, O,O,Z,2'd0, I,I, O,I,O,Z, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"lsu_addr7", O,O,Z,O,Z, I,O,Z,2'd0, I,I, O,O,I,32'h700, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"lsu_decerr",O,O,Z,O,Z, O,I,32'h0BAD_0BAD,2'd3, I,I, O,O,O,Z, O,I,I,32'h0BAD_0BAD,2'd3}; tbl.push_back(t);
        t = '{"lsu_req8",  O,O,Z,I,32'h704, O,O,Z,2'd0, I,I, O,I,O,Z, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"lsu_addr8", O,O,Z,O,Z, I,O,Z,2'd0, I,I, O,O,I,32'h704, O,O,O,Z,2'd0}; tbl.push_back(t);
        t = '{"lsu_slverr",O,O,Z,O,Z, O,I,32'h1111_2222,2'd2, I,I, O,O,O,Z, O,I,I,32'h1111_2222,2'd2}; tbl.push_back(t);
        t = '{"idle4",     O,O,Z,O,Z, O,O,Z,2'd0, I,I, O,O,O,Z, O,O,O,Z,2'd0}; tbl.push_back(t);

        #12;
        check_reset_state("reset_vals");
        @(negedge clock);
        reset = 1'b0;
        exp_last = 1'b0;

        foreach (tbl[k]) run_vec(tbl[k]);

        for (int r = 0; r < 4; r++) contend(r);

        // Reset asserted while a transaction waits in ADDR.
        t = '{"rst_req",  O,O,Z,I,32'h900, O,O,Z,2'd0, I,I, O,I,O,Z, O,O,O,Z,2'd0}; run_vec(t);
        t = '{"rst_addr", O,O,Z,O,Z, O,O,Z,2'd0, I,I, O,O,I,32'h900, O,O,O,Z,2'd0}; run_vec(t);
        @(negedge clock);
        t = '{"rst_mid", O,I,32'h104,I,32'h904, I,I,32'h5555_AAAA,2'd0, I,I, O,O,O,Z, O,O,O,Z,2'd0};
        drive(t);
        reset = 1'b1;
        #1 check_reset_state("rst_mid");
        exp_last = 1'b0;
        @(negedge clock);
        t = '{"init", O,O,Z,O,Z, O,O,Z,2'd0, I,I, O,O,O,Z, O,O,O,Z,2'd0};
        drive(t);
        #1 check_reset_state("rst_hold");
        reset = 1'b0;
        contend(4);
        contend(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
